// File: rtl/range_window_monitor_if.sv
// Sample/config/status bundle between a sample source and the range window
// monitor. The master drives samples and configuration and observes status;
// the slave is the monitor itself.
interface range_window_monitor_if #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
);
  logic                 sample_valid;
  logic [WIDTH-1:0]     sample;
  logic                 cfg_we;
  logic [WIDTH-1:0]     cfg_lo;
  logic [WIDTH-1:0]     cfg_hi;
  logic                 clr_count;
  logic                 in_range;
  logic                 z;
  logic                 enter_pulse;
  logic                 exit_pulse;
  logic [CNT_WIDTH-1:0] event_count;
  logic                 cfg_err;

  modport master (
    output sample_valid, sample, cfg_we, cfg_lo, cfg_hi, clr_count,
    input  in_range, z, enter_pulse, exit_pulse, event_count, cfg_err
  );

  modport slave (
    input  sample_valid, sample, cfg_we, cfg_lo, cfg_hi, clr_count,
    output in_range, z, enter_pulse, exit_pulse, event_count, cfg_err
  );
endinterface

// File: rtl/range_window_monitor.sv
// Range window monitor: flags valid unsigned samples strictly inside a
// programmable open window (lo, hi), debounces that into an in-window flag z
// with enter/exit pulses, and counts entries with a saturating counter.
module range_window_monitor #(
  parameter int WIDTH      = 4,
  parameter int LO_DEFAULT = 5,
  parameter int HI_DEFAULT = 10,
  parameter int DEBOUNCE   = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  range_window_monitor_if.slave mon
);

  localparam int RUN_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [WIDTH-1:0] LO_INIT = WIDTH'(LO_DEFAULT);
  localparam logic [WIDTH-1:0] HI_INIT = WIDTH'(HI_DEFAULT);
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(DEBOUNCE);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  typedef enum logic [1:0] {
    ST_OUT      = 2'd0,
    ST_PEND_IN  = 2'd1,
    ST_IN       = 2'd2,
    ST_PEND_OUT = 2'd3
  } state_t;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t               state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 in_range_q, in_range_d;
  logic                 z_q, z_d;
  logic                 enter_q, enter_d;
  logic                 exit_q, exit_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 win_empty;
  logic                 hit;

  // An empty window (lo >= hi) can never produce a hit.
  assign win_empty = (lo_q >= hi_q);
  assign hit       = (mon.sample > lo_q) && (mon.sample < hi_q) && !win_empty;

  // Next-state logic: configuration writes win over samples and restart the
  // debounce from OUT; otherwise the FSM only advances on valid samples.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    in_range_d = in_range_q;

    if (mon.cfg_we) begin
      lo_d       = mon.cfg_lo;
      hi_d       = mon.cfg_hi;
      state_d    = ST_OUT;
      run_d      = '0;
      in_range_d = 1'b0;
    end else if (mon.sample_valid) begin
      in_range_d = hit;
      case (state_q)
        ST_OUT: begin
          if (hit) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_IN;
              run_d   = '0;
            end else begin
              state_d = ST_PEND_IN;
              run_d   = RUN_ONE;
            end
          end
        end
        ST_PEND_IN: begin
          if (hit) begin
            if (run_q + RUN_ONE == RUN_TGT) begin
              state_d = ST_IN;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_ONE;
            end
          end else begin
            state_d = ST_OUT;
            run_d   = '0;
          end
        end
        ST_IN: begin
          if (!hit) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_OUT;
              run_d   = '0;
            end else begin
              state_d = ST_PEND_OUT;
              run_d   = RUN_ONE;
            end
          end
        end
        ST_PEND_OUT: begin
          if (!hit) begin
            if (run_q + RUN_ONE == RUN_TGT) begin
              state_d = ST_OUT;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_ONE;
            end
          end else begin
            state_d = ST_IN;
            run_d   = '0;
          end
        end
        default: begin
          state_d = ST_OUT;
          run_d   = '0;
        end
      endcase
    end

    // z follows the next state; a config-forced drop is silent.
    z_d     = (state_d == ST_IN) || (state_d == ST_PEND_OUT);
    enter_d = z_d && !z_q;
    exit_d  = !z_d && z_q && !mon.cfg_we;

    // Clear wins over accumulated count but still records a coincident entry.
    count_d = count_q;
    if (mon.clr_count) begin
      count_d = enter_d ? CNT_WIDTH'(1) : '0;
    end else if (enter_d) begin
      count_d = sat_inc(count_q);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_OUT;
      run_q      <= '0;
      lo_q       <= LO_INIT;
      hi_q       <= HI_INIT;
      in_range_q <= 1'b0;
      z_q        <= 1'b0;
      enter_q    <= 1'b0;
      exit_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      in_range_q <= in_range_d;
      z_q        <= z_d;
      enter_q    <= enter_d;
      exit_q     <= exit_d;
      count_q    <= count_d;
    end
  end

  assign mon.in_range    = in_range_q;
  assign mon.z           = z_q;
  assign mon.enter_pulse = enter_q;
  assign mon.exit_pulse  = exit_q;
  assign mon.event_count = count_q;
  assign mon.cfg_err     = win_empty;

endmodule

// File: tb/tb_range_window_monitor.sv
// Directed bench for range_window_monitor: a DEBOUNCE=3 instance for the
// debounce/config/reset behaviour and a DEBOUNCE=1, CNT_WIDTH=2 instance for
// the raw window sweep and counter saturation.
module tb_range_window_monitor;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  range_window_monitor_if #(.WIDTH(4), .CNT_WIDTH(8)) ia ();
  range_window_monitor_if #(.WIDTH(4), .CNT_WIDTH(2)) ib ();

  range_window_monitor #(
    .WIDTH(4), .LO_DEFAULT(5), .HI_DEFAULT(10), .DEBOUNCE(3), .CNT_WIDTH(8)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .mon   (ia.slave)
  );

  range_window_monitor #(
    .WIDTH(4), .LO_DEFAULT(5), .HI_DEFAULT(10), .DEBOUNCE(1), .CNT_WIDTH(2)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .mon   (ib.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic a_step(input logic v, input logic [3:0] s);
    ia.sample_valid = v;
    ia.sample       = s;
    @(posedge clk);
    #1;
    ia.sample_valid = 1'b0;
  endtask

  task automatic a_cfg(input logic [3:0] lo, input logic [3:0] hi);
    ia.cfg_we       = 1'b1;
    ia.cfg_lo       = lo;
    ia.cfg_hi       = hi;
    ia.sample_valid = 1'b1;
    ia.sample       = 4'd7;
    @(posedge clk);
    #1;
    ia.cfg_we       = 1'b0;
    ia.sample_valid = 1'b0;
  endtask

  task automatic b_step(input logic v, input logic [3:0] s, input logic clr);
    ib.sample_valid = v;
    ib.sample       = s;
    ib.clr_count    = clr;
    @(posedge clk);
    #1;
    ib.sample_valid = 1'b0;
    ib.clr_count    = 1'b0;
  endtask

  initial begin
    logic [3:0] glitch [6];
    logic       exp_hit;
    logic [1:0] exp_cnt;

    glitch = '{4'd7, 4'd7, 4'd3, 4'd7, 4'd7, 4'd7};

    ia.sample_valid = 1'b0; ia.sample = '0; ia.cfg_we = 1'b0;
    ia.cfg_lo = '0; ia.cfg_hi = '0; ia.clr_count = 1'b0;
    ib.sample_valid = 1'b0; ib.sample = '0; ib.cfg_we = 1'b0;
    ib.cfg_lo = '0; ib.cfg_hi = '0; ib.clr_count = 1'b0;

    // ---------------- instance A: DEBOUNCE=3 ----------------
    rst_a = 1'b1; rst_b = 1'b1;
    a_step(1'b1, 4'd7);
    rst_a = 1'b0; rst_b = 1'b0;
    chk("a_rst_in_range", ia.in_range, 1'b0);
    chk("a_rst_z", ia.z, 1'b0);
    chk("a_rst_enter", ia.enter_pulse, 1'b0);
    chk("a_rst_exit", ia.exit_pulse, 1'b0);
    chk("a_rst_count", ia.event_count, 8'd0);
    chk("a_rst_cfg_err", ia.cfg_err, 1'b0);

    // 7,7,7 -> enter after third
    a_step(1'b1, 4'd7);
    chk("a_777_inr1", ia.in_range, 1'b1);
    chk("a_777_z1", ia.z, 1'b0);
    a_step(1'b1, 4'd7);
    chk("a_777_z2", ia.z, 1'b0);
    a_step(1'b1, 4'd7);
    chk("a_777_z3", ia.z, 1'b1);
    chk("a_777_enter", ia.enter_pulse, 1'b1);
    chk("a_777_count", ia.event_count, 8'd1);
    a_step(1'b0, 4'd0);
    chk("a_777_enter_drop", ia.enter_pulse, 1'b0);
    chk("a_777_z_hold", ia.z, 1'b1);

    // From IN: 12,8,12,12,12
    a_step(1'b1, 4'd12);
    chk("a_out_z_12", ia.z, 1'b1);
    a_step(1'b1, 4'd8);
    chk("a_out_z_8", ia.z, 1'b1);
    a_step(1'b1, 4'd12);
    a_step(1'b1, 4'd12);
    chk("a_out_z_pre", ia.z, 1'b1);
    chk("a_out_exit_pre", ia.exit_pulse, 1'b0);
    a_step(1'b1, 4'd12);
    chk("a_out_z", ia.z, 1'b0);
    chk("a_out_exit", ia.exit_pulse, 1'b1);
    chk("a_out_enter", ia.enter_pulse, 1'b0);
    chk("a_out_count", ia.event_count, 8'd1);
    a_step(1'b0, 4'd0);
    chk("a_out_exit_drop", ia.exit_pulse, 1'b0);

    // Glitch 7,7,3,7,7,7 back-to-back
    for (int i = 0; i < 6; i++) begin
      a_step(1'b1, glitch[i]);
      if (i == 4) begin
        chk("a_gl_z_pre", ia.z, 1'b0);
        chk("a_gl_enter_pre", ia.enter_pulse, 1'b0);
      end
    end
    chk("a_gl_z", ia.z, 1'b1);
    chk("a_gl_enter", ia.enter_pulse, 1'b1);
    chk("a_gl_count", ia.event_count, 8'd2);

    // Leave the window: 12 x3
    for (int i = 0; i < 3; i++) a_step(1'b1, 4'd12);
    chk("a_leave_exit", ia.exit_pulse, 1'b1);

    // Same glitch sequence with idle gaps between samples
    for (int i = 0; i < 6; i++) begin
      a_step(1'b1, glitch[i]);
      if (i < 5) a_step(1'b0, 4'd7);
      if (i == 2) chk("a_gap_inr_hold0", ia.in_range, 1'b0);
      if (i == 3) chk("a_gap_inr_hold1", ia.in_range, 1'b1);
      if (i == 4) chk("a_gap_z_pre", ia.z, 1'b0);
    end
    chk("a_gap_z", ia.z, 1'b1);
    chk("a_gap_enter", ia.enter_pulse, 1'b1);
    chk("a_gap_count", ia.event_count, 8'd3);

    // cfg lo=9,hi=9 while IN, coincident with a valid sample
    a_cfg(4'd9, 4'd9);
    chk("a_cfg_z", ia.z, 1'b0);
    chk("a_cfg_exit", ia.exit_pulse, 1'b0);
    chk("a_cfg_err", ia.cfg_err, 1'b1);
    chk("a_cfg_inr", ia.in_range, 1'b0);
    chk("a_cfg_count", ia.event_count, 8'd3);
    for (int i = 0; i < 3; i++) a_step(1'b1, 4'd9);
    chk("a_empty_9_z", ia.z, 1'b0);
    chk("a_empty_9_inr", ia.in_range, 1'b0);
    for (int i = 0; i < 3; i++) a_step(1'b1, 4'd10);
    chk("a_empty_10_z", ia.z, 1'b0);

    // Wide window lo=0,hi=15
    a_cfg(4'd0, 4'd15);
    chk("a_wide_err", ia.cfg_err, 1'b0);
    for (int i = 0; i < 3; i++) a_step(1'b1, 4'd14);
    chk("a_wide_z", ia.z, 1'b1);
    chk("a_wide_enter", ia.enter_pulse, 1'b1);
    chk("a_wide_count", ia.event_count, 8'd4);
    a_step(1'b1, 4'd15);
    chk("a_wide_hi_edge", ia.in_range, 1'b0);

    // Reset while in PEND_IN discards the partial run
    a_cfg(4'd5, 4'd10);
    a_step(1'b1, 4'd7);
    a_step(1'b1, 4'd7);
    rst_a = 1'b1;
    a_step(1'b1, 4'd7);
    rst_a = 1'b0;
    chk("a_mid_rst_inr", ia.in_range, 1'b0);
    chk("a_mid_rst_z", ia.z, 1'b0);
    chk("a_mid_rst_count", ia.event_count, 8'd0);
    a_step(1'b1, 4'd7);
    a_step(1'b1, 4'd7);
    chk("a_fresh_z_pre", ia.z, 1'b0);
    a_step(1'b1, 4'd7);
    chk("a_fresh_z", ia.z, 1'b1);
    chk("a_fresh_count", ia.event_count, 8'd1);

    // ---------------- instance B: DEBOUNCE=1, CNT_WIDTH=2 ----------------
    for (int s = 0; s < 16; s++) begin
      b_step(1'b1, 4'(s), 1'b0);
      exp_hit = (s > 5) && (s < 10);
      chk($sformatf("b_sweep_%0d", s), ib.in_range, exp_hit);
      if (s == 6) chk("b_sweep_enter6", ib.enter_pulse, 1'b1);
      if (s == 10) chk("b_sweep_exit10", ib.exit_pulse, 1'b1);
    end
    chk("b_sweep_count", ib.event_count, 2'd1);

    b_step(1'b0, 4'd0, 1'b1);
    chk("b_clr_alone", ib.event_count, 2'd0);

    for (int i = 0; i < 5; i++) begin
      exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
      b_step(1'b1, 4'd7, 1'b0);
      chk($sformatf("b_sat_cnt_%0d", i), ib.event_count, exp_cnt);
      chk($sformatf("b_sat_enter_%0d", i), ib.enter_pulse, 1'b1);
      b_step(1'b1, 4'd0, 1'b0);
      chk($sformatf("b_sat_exit_%0d", i), ib.exit_pulse, 1'b1);
    end

    b_step(1'b1, 4'd7, 1'b1);
    chk("b_clr_enter_count", ib.event_count, 2'd1);
    chk("b_clr_enter_z", ib.z, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
